di_reg_terminal: RTL



---
 rtl/di_reg_terminal.sv | 192 +++++++++++++++++++
 1 files changed

// File: rtl/di_reg_terminal.sv
// DI responder terminal: NUM_REGS x 32-bit register bank behind the DI read/write handshake.
// Optional macro DI_REG_TERMINAL_WRITE_STROBE_EN adds a per-register write strobe output.
module di_reg_terminal #(
  parameter logic [15:0]  TERM_ADDR     = 16'h0000,
  parameter int           NUM_REGS      = 16,
  parameter logic [255:0] RO_MASK       = '0,
  parameter int           READ_LATENCY  = 2,
  parameter int           WRITE_LATENCY = 1
) (
  input  logic                     ifclk,
  input  logic                     resetb,
  input  logic [15:0]              di_term_addr,
  input  logic [31:0]              di_reg_addr,
  input  logic [31:0]              di_len,
  input  logic                     di_read_mode,
  input  logic                     di_read_req,
  input  logic                     di_read,
  output logic                     di_read_rdy,
  output logic [31:0]              di_reg_datao,
  input  logic                     di_write_mode,
  input  logic                     di_write,
  output logic                     di_write_rdy,
  input  logic [31:0]              di_reg_datai,
  output logic [15:0]              di_transfer_status,
  output logic [NUM_REGS*32-1:0]   reg_q,
  input  logic [NUM_REGS*32-1:0]   reg_ro_in,
`ifdef DI_REG_TERMINAL_WRITE_STROBE_EN
  output logic [NUM_REGS-1:0]      reg_wr_strobe,
`endif
  output logic [1:0]               dbg_state_o
);

  // Handshake: a read is offered by di_read_rdy and taken when di_read is sampled high;
  // a write is taken when di_write is sampled high while di_write_rdy is high.

  localparam int AW = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam int CW = 16;

  typedef enum logic [1:0] {IDLE, RD_WAIT, RD_VALID, WR_BUSY} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [31:0]     addr_q, addr_d;
  logic [31:0]     datao_q, datao_d;
  logic [15:0]     status_q, status_d;
  logic            rdy_q, rdy_d;
  logic [31:0]     regs_q [NUM_REGS];

  logic            sel;
  logic            wr_commit;
  logic [AW-1:0]   wr_idx, rd_idx;
  logic [15:0]     wr_status, rd_status;
  logic [31:0]     lane_mask, rd_data;

  assign sel    = (di_term_addr == TERM_ADDR);
  assign wr_idx = di_reg_addr[AW-1:0];
  assign rd_idx = addr_q[AW-1:0];

  always_comb begin
    wr_status = 16'd0;
    if (di_reg_addr >= 32'(NUM_REGS))  wr_status = 16'd1;
    else if (RO_MASK[wr_idx])          wr_status = 16'd2;
  end

  always_comb begin
    rd_status = 16'd0;
    rd_data   = 32'h0;
    if (addr_q >= 32'(NUM_REGS))       rd_status = 16'd1;
    else if (RO_MASK[rd_idx])          rd_data   = reg_ro_in[32*rd_idx +: 32];
    else                               rd_data   = regs_q[rd_idx];
  end

  always_comb begin
    case (di_len)
      32'd4:   lane_mask = 32'hFFFF_FFFF;
      32'd2:   lane_mask = 32'h0000_FFFF;
      default: lane_mask = 32'h0000_00FF;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    addr_d       = addr_q;
    datao_d      = datao_q;
    status_d     = status_q;
    rdy_d        = rdy_q;
    wr_commit    = 1'b0;
    di_write_rdy = 1'b0;
    case (state_q)
      IDLE: begin
        rdy_d        = 1'b0;
        di_write_rdy = sel && di_write_mode;
        // A simultaneous read request loses to the write.
        if (di_write && sel && di_write_mode) begin
          wr_commit = 1'b1;
          status_d  = wr_status;
          if (WRITE_LATENCY > 0) begin
            state_d = WR_BUSY;
            cnt_d   = CW'(WRITE_LATENCY);
          end
        end else if (di_read_req && sel) begin
          addr_d  = di_reg_addr;
          cnt_d   = CW'(READ_LATENCY - 1);
          state_d = RD_WAIT;
        end
      end
      RD_WAIT: begin
        if (cnt_q == '0) begin
          datao_d  = rd_data;
          status_d = rd_status;
          rdy_d    = 1'b1;
          state_d  = RD_VALID;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      RD_VALID: begin
        if ((sel && di_read) || !di_read_mode) begin
          rdy_d   = 1'b0;
          state_d = IDLE;
        end
      end
      WR_BUSY: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CW'(1);
        end else begin
          di_write_rdy = sel;
          if (!di_write_mode) begin
            state_d = IDLE;
          end else if (sel && di_write) begin
            wr_commit = 1'b1;
            status_d  = wr_status;
            cnt_d     = CW'(WRITE_LATENCY);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge ifclk or negedge resetb) begin
    if (!resetb) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      addr_q   <= '0;
      datao_q  <= '0;
      status_q <= '0;
      rdy_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      addr_q   <= addr_d;
      datao_q  <= datao_d;
      status_q <= status_d;
      rdy_q    <= rdy_d;
    end
  end

  always_ff @(posedge ifclk or negedge resetb) begin
    if (!resetb) begin
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
    end else if (wr_commit && (wr_status == 16'd0)) begin
      regs_q[wr_idx] <= (regs_q[wr_idx] & ~lane_mask) | (di_reg_datai & lane_mask);
    end
  end

  for (genvar i = 0; i < NUM_REGS; i++) begin : g_word
    assign reg_q[32*i +: 32] = RO_MASK[i] ? reg_ro_in[32*i +: 32] : regs_q[i];
  end

`ifdef DI_REG_TERMINAL_WRITE_STROBE_EN
  logic [NUM_REGS-1:0] strobe_q;

  always_ff @(posedge ifclk or negedge resetb) begin
    if (!resetb) begin
      strobe_q <= '0;
    end else begin
      strobe_q <= '0;
      if (wr_commit && (wr_status == 16'd0)) strobe_q[wr_idx] <= 1'b1;
    end
  end

  assign reg_wr_strobe = strobe_q;
`endif

  assign di_read_rdy        = rdy_q && sel;
  assign di_reg_datao       = datao_q;
  assign di_transfer_status = status_q;
  assign dbg_state_o        = state_q;

endmodule
